// File: rtl/uart_bus_if.sv
// CPU-side register interface for a UART core.
// Edge-detects the chip select so each access acts exactly once, decodes a
// small register map, issues single-cycle FIFO push/pop pulses and holds the
// baud divisor, committed atomically from two shadow bytes.
module uart_bus_if #(
  parameter logic [20:0] DVSR_RST = 21'd325
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        we,
  input  logic [2:0]  addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        irq,
  output logic        rd_uart,
  output logic        wr_uart,
  output logic [7:0]  w_data,
  output logic [20:0] dvsr,
  input  logic [7:0]  r_data,
  input  logic        rx_empty,
  input  logic        tx_full
);

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_STATUS = 3'd1;
  localparam logic [2:0] A_CTRL   = 3'd2;
  localparam logic [2:0] A_DVSR_L = 3'd3;
  localparam logic [2:0] A_DVSR_M = 3'd4;
  localparam logic [2:0] A_DVSR_H = 3'd5;

  // Decoded bus access, valid only on the strobe cycle.
  typedef struct packed {
    logic       wr;
    logic       rd;
    logic [2:0] sel;
    logic [7:0] din;
  } bus_req_t;

  logic       cs_q;
  logic       strobe;
  bus_req_t   req;
  logic       tx_ovf;
  logic [1:0] ctrl;       // {tx_irq_en, rx_irq_en}
  logic [7:0] shadow_l;
  logic [7:0] shadow_m;
  logic [7:0] rd_mux;

  // cs history; resets high so a cs held across reset release is ignored
  // until it has been seen low once.
  always_ff @(posedge clk) begin
    if (reset) cs_q <= 1'b1;
    else       cs_q <= cs;
  end

  // Reset masks the strobe so an access colliding with reset has no effect.
  assign strobe  = cs & ~cs_q & ~reset;
  assign req.wr  = strobe & we;
  assign req.rd  = strobe & ~we;
  assign req.sel = addr;
  assign req.din = cpu_din;

  // FIFO pulses live only during the strobe cycle; FWFT head is consumed
  // on the same edge that captures it into cpu_dout.
  assign wr_uart = req.wr & (req.sel == A_DATA) & ~tx_full;
  assign rd_uart = req.rd & (req.sel == A_DATA) & ~rx_empty;
  assign w_data  = wr_uart ? req.din : 8'h00;

  // Read data selection for the addressed register.
  always_comb begin
    rd_mux = 8'h00;
    case (req.sel)
      A_DATA:   rd_mux = rx_empty ? 8'h00 : r_data;
      A_STATUS: rd_mux = {irq, 4'b0000, tx_ovf, tx_full, ~rx_empty};
      A_CTRL:   rd_mux = {6'b000000, ctrl};
      A_DVSR_L: rd_mux = shadow_l;
      A_DVSR_M: rd_mux = shadow_m;
      A_DVSR_H: rd_mux = {3'b000, dvsr[20:16]};
      default:  rd_mux = 8'h00;
    endcase
  end

  // Control, overflow flag, shadow bytes and atomic divisor commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_ovf   <= 1'b0;
      ctrl     <= 2'b00;
      shadow_l <= 8'h00;
      shadow_m <= 8'h00;
      dvsr     <= DVSR_RST;
    end else if (req.wr) begin
      case (req.sel)
        A_DATA:   if (tx_full) tx_ovf <= 1'b1;
        A_STATUS: tx_ovf <= 1'b0;
        A_CTRL:   ctrl <= req.din[1:0];
        A_DVSR_L: shadow_l <= req.din;
        A_DVSR_M: shadow_m <= req.din;
        A_DVSR_H: dvsr <= {req.din[4:0], shadow_m, shadow_l};
        default:  ;
      endcase
    end
  end

  // Read data register: loads on read strobes only, holds otherwise.
  always_ff @(posedge clk) begin
    if (reset)       cpu_dout <= 8'h00;
    else if (req.rd) cpu_dout <= rd_mux;
  end

  // Registered interrupt request from enabled FIFO conditions.
  always_ff @(posedge clk) begin
    if (reset) irq <= 1'b0;
    else       irq <= (ctrl[0] & ~rx_empty) | (ctrl[1] & ~tx_full);
  end

endmodule

// File: tb/tb_uart_bus_if.sv
// Randomized scoreboard bench for uart_bus_if with a register-level model.
module tb_uart_bus_if;

  logic        clk = 1'b0;
  logic        reset, cs, we;
  logic [2:0]  addr;
  logic [7:0]  cpu_din, cpu_dout, w_data, r_data;
  logic        irq, rd_uart, wr_uart, rx_empty, tx_full;
  logic [20:0] dvsr;

  uart_bus_if #(.DVSR_RST(21'd325)) dut (
    .clk(clk), .reset(reset), .cs(cs), .we(we), .addr(addr),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .irq(irq),
    .rd_uart(rd_uart), .wr_uart(wr_uart), .w_data(w_data),
    .dvsr(dvsr), .r_data(r_data), .rx_empty(rx_empty), .tx_full(tx_full)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  typedef struct { bit is_wr; logic [7:0] data; } pulse_t;
  pulse_t     pulse_q[$];
  logic [7:0] rdata_q[$];

  // Reference register state
  logic [1:0]  m_ctrl;
  logic [7:0]  m_sl, m_sm, m_last;
  logic [20:0] m_dvsr;
  logic        m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_irq();
    return (m_ctrl[0] & ~rx_empty) | (m_ctrl[1] & ~tx_full);
  endfunction

  task automatic model_reset();
    m_ctrl = 2'b00; m_sl = 8'h00; m_sm = 8'h00; m_last = 8'h00;
    m_dvsr = 21'd325; m_ovf = 1'b0;
  endtask

  // One CPU access with cs held 'hold' cycles; FIFO flags must already be set.
  task automatic access(input bit w, input logic [2:0] a, input logic [7:0] d, input int hold);
    pulse_t p;
    logic [7:0] v;
    if (w) begin
      case (a)
        3'd0: if (!tx_full) begin p.is_wr = 1'b1; p.data = d; pulse_q.push_back(p); end
              else m_ovf = 1'b1;
        3'd1: m_ovf = 1'b0;
        3'd2: m_ctrl = d[1:0];
        3'd3: m_sl = d;
        3'd4: m_sm = d;
        3'd5: m_dvsr = {d[4:0], m_sm, m_sl};
        default: ;
      endcase
    end else begin
      case (a)
        3'd0: begin
          v = rx_empty ? 8'h00 : r_data;
          if (!rx_empty) begin p.is_wr = 1'b0; p.data = 8'h00; pulse_q.push_back(p); end
        end
        3'd1: v = {m_irq(), 4'b0000, m_ovf, tx_full, ~rx_empty};
        3'd2: v = {6'b0, m_ctrl};
        3'd3: v = m_sl;
        3'd4: v = m_sm;
        3'd5: v = {3'b0, m_dvsr[20:16]};
        default: v = 8'h00;
      endcase
      m_last = v;
      rdata_q.push_back(v);
    end
    @(posedge clk); #1;
    cs = 1'b1; we = w; addr = a; cpu_din = d;
    repeat (hold) begin @(posedge clk); #1; end
    cs = 1'b0;
    @(posedge clk); #1;
    chk("dvsr", dvsr, m_dvsr);
    chk("cpu_dout_hold", cpu_dout, m_last);
    chk("irq", irq, m_irq());
  endtask

  // Monitor: pops expected pulses and read data as the DUT presents them.
  logic cs_prev = 1'b1;
  bit   rd_pend = 1'b0;
  always @(negedge clk) begin
    pulse_t p;
    if (rd_pend) begin
      rd_pend = 1'b0;
      if (rdata_q.size() == 0) chk("rdata_unexpected", 1, 0);
      else chk("cpu_dout", cpu_dout, rdata_q.pop_front());
    end
    if (wr_uart || rd_uart) begin
      if (pulse_q.size() == 0) chk("unexpected_pulse", {wr_uart, rd_uart}, 0);
      else begin
        p = pulse_q.pop_front();
        chk("pulse_kind", {wr_uart, rd_uart}, p.is_wr ? 2'b10 : 2'b01);
        if (p.is_wr) chk("w_data", w_data, p.data);
      end
    end
    if (cs && !cs_prev && !reset && !we) rd_pend = 1'b1;
    cs_prev = reset ? 1'b1 : cs;
  end

  initial begin
    // Reset with an access already held high across release
    reset = 1'b1; cs = 1'b1; we = 1'b1; addr = 3'd0; cpu_din = 8'h41;
    tx_full = 1'b0; rx_empty = 1'b1; r_data = 8'h00;
    model_reset();
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b0;
    chk("rst_cpu_dout", cpu_dout, 8'h00);
    chk("rst_irq", irq, 1'b0);
    chk("rst_wr_uart", wr_uart, 1'b0);
    chk("rst_rd_uart", rd_uart, 1'b0);
    chk("rst_w_data", w_data, 8'h00);
    chk("rst_dvsr", dvsr, 21'd325);
    repeat (3) begin @(posedge clk); #1; end
    chk("no_strobe_after_rst", wr_uart, 1'b0);
    cs = 1'b0;
    @(posedge clk); #1;

    // DATA write held 4 cycles -> one push
    access(1, 3'd0, 8'h41, 4);
    // Overflow then clear
    tx_full = 1'b1;
    access(1, 3'd0, 8'h99, 2);
    access(0, 3'd1, 8'h00, 1);
    chk("status_ovf_set", cpu_dout[2], 1'b1);
    access(1, 3'd1, 8'h00, 1);
    access(0, 3'd1, 8'h00, 1);
    chk("status_ovf_clr", cpu_dout[2], 1'b0);
    tx_full = 1'b0;
    // DATA reads
    r_data = 8'h5A; rx_empty = 1'b0;
    access(0, 3'd0, 8'h00, 3);
    rx_empty = 1'b1;
    access(0, 3'd0, 8'h00, 2);
    // Divisor commit
    access(1, 3'd3, 8'h45, 1);
    access(1, 3'd4, 8'h01, 1);
    chk("dvsr_unchanged", dvsr, 21'd325);
    access(1, 3'd5, 8'h00, 1);
    chk("dvsr_commit", dvsr, 21'h000145);
    access(0, 3'd3, 8'h00, 1);
    access(0, 3'd5, 8'h00, 1);
    // irq timing
    tx_full = 1'b1; rx_empty = 1'b1;
    access(1, 3'd2, 8'h01, 1);
    @(posedge clk); #1;
    rx_empty = 1'b0;
    chk("irq_before", irq, 1'b0);
    @(posedge clk); #1;
    chk("irq_rise", irq, 1'b1);
    access(1, 3'd2, 8'h00, 1);
    // Reset colliding with a DATA write strobe
    tx_full = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; cs = 1'b1; we = 1'b1; addr = 3'd0; cpu_din = 8'h77;
    @(posedge clk); #1;
    reset = 1'b0; model_reset();
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_coll_dvsr", dvsr, 21'd325);
    cs = 1'b0;
    @(posedge clk); #1;
    access(1, 3'd0, 8'h3C, 1);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      tx_full  = 1'($urandom_range(0, 1));
      rx_empty = 1'($urandom_range(0, 1));
      r_data   = 8'($urandom);
      access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
             $urandom_range(1, 4));
    end

    repeat (3) begin @(posedge clk); #1; end
    chk("pulses_left", pulse_q.size(), 0);
    chk("reads_left", rdata_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
